layer_engine: RTL and testbench

//  Parametrised successor to the single-channel MAC/pool/ReLU layer. Computes DEPTH_NB output channels in parallel.

---
 rtl/layer_pkg.sv | 31 +++
 rtl/layer_lane.sv | 107 ++++++++++
 rtl/layer_engine.sv | 145 ++++++++++++++
 tb/tb_layer_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer_engine MAC/pool/ReLU datapath.
package layer_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } up_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int ker_lsb(input int d, input int g, input int group_nb, input int ker_w);
        return (d * group_nb + g) * ker_w;
    endfunction

    function automatic int img_lsb(input int g, input int img_w);
        return g * img_w;
    endfunction

    function automatic int res_lsb(input int d, input int img_w);
        return d * img_w;
    endfunction

endpackage

// File: rtl/layer_lane.sv
// One output channel: per-beat dot product, accumulator, round/narrow/ReLU, pool and result registers.
// Narrowing clamps when LAYER_SATURATE_EN is defined, otherwise wraps (two's complement).
module layer_lane
    import layer_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          m_en_i,
    input  logic                          a_en_i,
    input  logic                          a_last_i,
    input  logic                          p_en_i,
    input  logic                          p_first_i,
    input  logic                          load_i,
    input  logic [5:0]                    shift_i,
    input  logic                          relu_i,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] image_i,
    input  logic [GROUP_NB*KER_WIDTH-1:0] kernel_i,
    output logic [IMG_WIDTH-1:0]          result_o
);

`ifdef LAYER_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] NARROW_MAX =
        {{(ACC_WIDTH-IMG_WIDTH+2){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] NARROW_MIN =
        {{(ACC_WIDTH-IMG_WIDTH+2){1'b1}}, {(IMG_WIDTH-1){1'b0}}};
`endif

    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [5:0]                  sh
    );
        logic signed [ACC_WIDTH:0] wide;
        wide = (ACC_WIDTH+1)'(acc);
        if (sh != 6'd0) wide = wide + ((ACC_WIDTH+1)'(1) << (sh - 6'd1));
        return wide >>> sh;
    endfunction

    function automatic logic signed [IMG_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH:0] r);
`ifdef LAYER_SATURATE_EN
        if (r > NARROW_MAX) return NARROW_MAX[IMG_WIDTH-1:0];
        if (r < NARROW_MIN) return NARROW_MIN[IMG_WIDTH-1:0];
        return r[IMG_WIDTH-1:0];
`else
        return r[IMG_WIDTH-1:0];
`endif
    endfunction

    function automatic logic signed [IMG_WIDTH-1:0] apply_relu(
        input logic signed [IMG_WIDTH-1:0] v,
        input logic                        en
    );
        return (en && v < 0) ? '0 : v;
    endfunction

    logic signed [ACC_WIDTH-1:0] sum_d;
    logic signed [ACC_WIDTH-1:0] m_p0_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_p1_q;
    logic signed [IMG_WIDTH-1:0] post_p1;
    logic signed [IMG_WIDTH-1:0] pool_q;
    logic signed [IMG_WIDTH-1:0] res_q;

    // Stage M: sign-extend every operand so the lane sum is exact in ACC_WIDTH.
    always_comb begin
        sum_d = '0;
        for (int g = 0; g < GROUP_NB; g++) begin
            sum_d = sum_d
                  + ACC_WIDTH'($signed(image_i[img_lsb(g, IMG_WIDTH) +: IMG_WIDTH]))
                  * ACC_WIDTH'($signed(kernel_i[g*KER_WIDTH +: KER_WIDTH]));
        end
    end

    always_ff @(posedge clk) begin
        if (m_en_i) m_p0_q <= sum_d;
    end

    always_comb post_p1 = apply_relu(narrow(round_shift(acc_p1_q, shift_i)), relu_i);

    // Stage A hands the finished sum to P and restarts from zero in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            acc_p1_q <= '0;
            pool_q   <= '0;
            res_q    <= '0;
        end else begin
            if (a_en_i) begin
                if (a_last_i) begin
                    acc_p1_q <= acc_q + m_p0_q;
                    acc_q    <= '0;
                end else begin
                    acc_q    <= acc_q + m_p0_q;
                end
            end
            if (p_en_i && (p_first_i || post_p1 > pool_q)) pool_q <= post_p1;
            if (load_i) res_q <= pool_q;
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/layer_engine.sv
// DEPTH_NB-channel MAC/pool/ReLU layer with val/rdy streams on both sides.
// Build option LAYER_SATURATE_EN: saturating narrowing instead of wrap.
module layer_engine
    import layer_pkg::*;
#(
    parameter int DEPTH_NB  = 4,
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int POOL_MAX  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [5:0]                             cfg_shift,
    input  logic [clog2(POOL_MAX+1)-1:0]           cfg_pool,
    input  logic                                   cfg_relu,
    input  logic [DEPTH_NB*GROUP_NB*KER_WIDTH-1:0] kernel,
    output logic                                   kernel_rdy,
    input  logic [GROUP_NB*IMG_WIDTH-1:0]          image,
    input  logic                                   image_last,
    input  logic                                   image_val,
    output logic                                   image_rdy,
    output logic [DEPTH_NB*IMG_WIDTH-1:0]          result,
    output logic                                   result_val,
    input  logic                                   result_rdy
);

    localparam int POOL_W = clog2(POOL_MAX + 1);

    typedef struct packed {
        logic [5:0]        shift;
        logic [POOL_W-1:0] pool;
        logic              relu;
    } cfg_t;

    function automatic logic [POOL_W-1:0] pool_clamp(input logic [POOL_W-1:0] p);
        if (p == '0) return POOL_W'(1);
        if (p > POOL_W'(POOL_MAX)) return POOL_W'(POOL_MAX);
        return p;
    endfunction

    up_state_e         state_q, state_d;
    logic              rdy_en_q;
    logic              win_start_q;
    logic [POOL_W-1:0] in_cnt_q;
    logic [POOL_W-1:0] pool_cnt_q;
    cfg_t              cfg_q, cfg_in, cfg_beat, cfg_p0_q, cfg_p1_q;
    logic              vld_p0_q, last_p0_q, vld_p1_q, done_q;
    logic              accept, completes, stall, p_fire, load;

    assign cfg_in     = '{shift: cfg_shift, pool: pool_clamp(cfg_pool), relu: cfg_relu};
    assign cfg_beat   = win_start_q ? cfg_in : cfg_q;
    assign image_rdy  = rdy_en_q && (state_q != HOLD);
    assign kernel_rdy = image_rdy;
    assign result_val = (state_q == HOLD);
    assign accept     = image_val && image_rdy;
    assign completes  = (pool_cnt_q + 1'b1) == cfg_p1_q.pool;
    // While a result is held, freeze P if it would complete a window or clobber a pending one.
    assign stall      = (state_q == HOLD) && vld_p1_q && (done_q || completes);
    assign p_fire     = vld_p1_q && !stall;
    assign load       = done_q && (state_q != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            rdy_en_q    <= 1'b0;
            win_start_q <= 1'b1;
            in_cnt_q    <= '0;
            cfg_q       <= '0;
            vld_p0_q    <= 1'b0;
            last_p0_q   <= 1'b0;
            cfg_p0_q    <= '0;
            vld_p1_q    <= 1'b0;
            cfg_p1_q    <= '0;
            pool_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (accept) begin
                if (win_start_q) cfg_q <= cfg_in;
                if (image_last && (in_cnt_q + 1'b1) == cfg_beat.pool) begin
                    in_cnt_q    <= '0;
                    win_start_q <= 1'b1;
                end else begin
                    if (image_last) in_cnt_q <= in_cnt_q + 1'b1;
                    win_start_q <= 1'b0;
                end
            end
            if (!stall) begin
                vld_p0_q  <= accept;
                last_p0_q <= image_last;
                cfg_p0_q  <= cfg_beat;
                vld_p1_q  <= vld_p0_q && last_p0_q;
                cfg_p1_q  <= cfg_p0_q;
            end
            if (p_fire) pool_cnt_q <= completes ? '0 : pool_cnt_q + 1'b1;
            done_q <= (p_fire && completes) || (done_q && !load);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (load)                          state_d = HOLD;
                else if (accept && image_last)     state_d = FLUSH;
            end
            FLUSH: begin
                if (load)                          state_d = HOLD;
                else if (p_fire && !completes && !(vld_p0_q && last_p0_q)
                         && !(accept && image_last)) state_d = ACCUM;
            end
            HOLD: begin
                if (result_rdy)                    state_d = ACCUM;
            end
            default:                               state_d = ACCUM;
        endcase
    end

    for (genvar d = 0; d < DEPTH_NB; d++) begin : g_lane
        layer_lane #(
            .GROUP_NB  (GROUP_NB),
            .IMG_WIDTH (IMG_WIDTH),
            .KER_WIDTH (KER_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .m_en_i    (accept),
            .a_en_i    (vld_p0_q && !stall),
            .a_last_i  (last_p0_q),
            .p_en_i    (p_fire),
            .p_first_i (pool_cnt_q == '0),
            .load_i    (load),
            .shift_i   (cfg_p1_q.shift),
            .relu_i    (cfg_p1_q.relu),
            .image_i   (image),
            .kernel_i  (kernel[ker_lsb(d, 0, GROUP_NB, KER_WIDTH) +: GROUP_NB*KER_WIDTH]),
            .result_o  (result[res_lsb(d, IMG_WIDTH) +: IMG_WIDTH])
        );
    end

endmodule

// File: tb/tb_layer_engine.sv
// Bench for layer_engine: directed scenarios, then random dot products against a behavioural model.
module tb_layer_engine;

    logic         clk;
    logic         rst_n;
    logic [5:0]   cfg_shift;
    logic [2:0]   cfg_pool;
    logic         cfg_relu;
    logic [255:0] kernel;
    logic         kernel_rdy;
    logic [63:0]  image;
    logic         image_last, image_val, image_rdy;
    logic [63:0]  result;
    logic         result_val, result_rdy;
    logic         mon_en, mon_rdy, dir_rdy;

    int           checks, failures, got_cnt, push_cnt;
    logic [63:0]  exp_q[$];

    assign result_rdy = mon_en ? mon_rdy : dir_rdy;

    layer_engine u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_shift  (cfg_shift),
        .cfg_pool   (cfg_pool),
        .cfg_relu   (cfg_relu),
        .kernel     (kernel),
        .kernel_rdy (kernel_rdy),
        .image      (image),
        .image_last (image_last),
        .image_val  (image_val),
        .image_rdy  (image_rdy),
        .result     (result),
        .result_val (result_val),
        .result_rdy (result_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [255:0] ker_all(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic signed [15:0] model_post(input longint acc, input int sh, input bit relu);
        longint r;
        logic signed [15:0] n;
        r = acc + ((sh != 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
        r = r >>> sh;
`ifdef LAYER_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        n = r[15:0];
        if (relu && n < 0) n = 0;
        return n;
    endfunction

    task automatic drive(input logic [63:0] img, input logic [255:0] ker, input bit last);
        int guard;
        @(negedge clk);
        image = img; kernel = ker; image_last = last; image_val = 1'b1;
        guard = 0;
        while (!image_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!image_rdy) check_eq("accept_timeout", image_rdy, 1);
        @(posedge clk);
        #1 image_val = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [63:0] exp);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_val_early"}, result_val, 0);
        end
        @(posedge clk); #1;
        check_eq({tag, "_val"}, result_val, 1);
        check_eq(tag, result, exp);
    endtask

    task automatic take_result();
        @(negedge clk); dir_rdy = 1'b1;
        @(posedge clk); #1; dir_rdy = 1'b0;
        check_eq("hs_image_rdy", image_rdy, 1);
        check_eq("hs_result_val", result_val, 0);
    endtask

    initial begin
        mon_rdy = 1'b0;
        forever begin
            @(negedge clk);
            mon_rdy = ($urandom_range(0, 3) != 0);
            if (mon_en && result_val && mon_rdy) begin
                if (exp_q.size() == 0) check_eq("unexpected_result", result_val, 0);
                else check_eq("rand_result", result, exp_q.pop_front());
                got_cnt++;
            end
        end
    end

    initial begin
        longint            acc[4];
        logic signed [15:0] mx[4];
        logic signed [15:0] r, kw, iv;
        logic [63:0]       img, pk;
        logic [255:0]      ker;
        int                dps, dp, nb, w_shift, guard;
        bit                w_relu;

        checks = 0; failures = 0; got_cnt = 0; push_cnt = 0;
        rst_n = 1'b0; image_val = 1'b0; image_last = 1'b0; image = '0; kernel = '0;
        cfg_shift = 6'd0; cfg_pool = 3'd1; cfg_relu = 1'b0; dir_rdy = 1'b0; mon_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_image_rdy", image_rdy, 0);
        check_eq("rst_kernel_rdy", kernel_rdy, 0);
        check_eq("rst_result_val", result_val, 0);
        check_eq("rst_result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_image_rdy", image_rdy, 1);
        check_eq("post_rst_kernel_rdy", kernel_rdy, 1);

        // Two-beat dot product: 10 + (-26) = -16 on every lane.
        drive(pack4(4, 3, 2, 1), ker_all(16'd1), 1'b0);
        drive(pack4(-8, -7, -6, -5), ker_all(16'd1), 1'b1);
        expect_result("t1_neg", {4{16'hFFF0}});
        take_result();

        cfg_relu = 1'b1;
        drive(pack4(4, 3, 2, 1), ker_all(16'd1), 1'b0);
        drive(pack4(-8, -7, -6, -5), ker_all(16'd1), 1'b1);
        expect_result("t2_relu", 64'h0);
        take_result();
        cfg_relu = 1'b0;

        cfg_pool = 3'd2;
        drive(pack4(1, 2, 3, 4), ker_all(16'd1), 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("t3_no_early", result_val, 0);
        end
        drive(pack4(5, 5, 5, 5), ker_all(16'd1), 1'b1);
        expect_result("t3_pool2", {4{16'd20}});

        // Stay in HOLD with a beat offered; it must wait for the handshake.
        cfg_pool = 3'd1;
        @(negedge clk);
        image = pack4(1, 1, 1, 1); kernel = ker_all(16'd1); image_last = 1'b1; image_val = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("t4_result_stable", result, {4{16'd20}});
            check_eq("t4_image_stall", image_rdy, 0);
            check_eq("t4_val_held", result_val, 1);
        end
        @(negedge clk); dir_rdy = 1'b1;
        @(posedge clk); #1; dir_rdy = 1'b0;
        check_eq("t4_rdy_next", image_rdy, 1);
        @(posedge clk); #1; image_val = 1'b0;
        expect_result("t4_held_beat", {4{16'd4}});
        take_result();

        drive({4{16'h7FFF}}, ker_all(16'h7FFF), 1'b1);
`ifdef LAYER_SATURATE_EN
        expect_result("t5_narrow", {4{16'h7FFF}});
`else
        expect_result("t5_narrow", {4{16'h0004}});
`endif
        take_result();
        cfg_shift = 6'd2;
        drive(pack4(1, 2, 3, 1), ker_all(16'd1), 1'b1);
        expect_result("t5_round", {4{16'd2}});
        take_result();
        cfg_shift = 6'd0;

        // Reset while a partial sum is in flight and a result is held.
        drive(pack4(2, 2, 2, 2), ker_all(16'd1), 1'b1);
        drive(pack4(100, 100, 100, 100), ker_all(16'd1), 1'b0);
        guard = 0;
        while (!result_val && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("t6_pre_result", result, {4{16'd8}});
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check_eq("t6_rst_val", result_val, 0);
        check_eq("t6_rst_result", result, 0);
        check_eq("t6_rst_rdy", image_rdy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        drive(pack4(1, 1, 1, 1), ker_all(16'd1), 1'b1);
        expect_result("t6_after_rst", {4{16'd4}});
        take_result();

        // Random windows; config is randomised on every beat but only the window's first beat counts.
        mon_en = 1'b1;
        for (int w = 0; w < 30; w++) begin
            dps = 1; dp = 0; w_shift = 0; w_relu = 1'b0;
            while (dp < dps) begin
                nb = $urandom_range(1, 4);
                for (int d = 0; d < 4; d++) acc[d] = 0;
                for (int b = 0; b < nb; b++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    img = {$urandom(), $urandom()};
                    for (int i = 0; i < 8; i++) ker[i*32 +: 32] = $urandom();
                    cfg_shift = 6'($urandom_range(0, 20));
                    cfg_pool  = 3'($urandom_range(0, 7));
                    cfg_relu  = 1'($urandom_range(0, 1));
                    drive(img, ker, b == nb - 1);
                    if (dp == 0 && b == 0) begin
                        w_shift = int'(cfg_shift);
                        w_relu  = cfg_relu;
                        dps     = (cfg_pool == 0) ? 1 : (cfg_pool > 4) ? 4 : int'(cfg_pool);
                    end
                    for (int d = 0; d < 4; d++) begin
                        for (int g = 0; g < 4; g++) begin
                            kw = ker[(d*4+g)*16 +: 16];
                            iv = img[g*16 +: 16];
                            acc[d] += longint'(kw) * longint'(iv);
                        end
                    end
                end
                for (int d = 0; d < 4; d++) begin
                    r = model_post(acc[d], w_shift, w_relu);
                    if (dp == 0 || r > mx[d]) mx[d] = r;
                end
                dp++;
            end
            for (int d = 0; d < 4; d++) pk[d*16 +: 16] = mx[d];
            exp_q.push_back(pk);
            push_cnt++;
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("result_count", got_cnt, push_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
